// File: rtl/universal_register_pkg.sv
// Shared mode codes for the universal register datapath and its bench.
package universal_register_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_INC  = 3'b110;
    localparam logic [2:0] MODE_DEC  = 3'b111;

    // True when the bit leaving the register exits from the LSB end.
    function automatic logic exits_lsb(input logic [2:0] mode);
        logic res;
        res = 1'b0;
        case (mode)
            MODE_SHR, MODE_ROR: res = 1'b1;
            default:            res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/universal_register_next.sv
// Combinational next-state logic: computes {carry_nxt, q_nxt} for every mode.
module universal_register_next
    import universal_register_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic             carry,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q_nxt,
    output logic             carry_nxt
);

    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0] inc_s;
    logic [WIDTH:0] dec_s;

    // Bit WIDTH of the widened sum/difference is the carry/borrow out.
    assign inc_s = {1'b0, q} + ONE;
    assign dec_s = {1'b0, q} - ONE;

    // Mode decode into next register value and carry.
    always_comb begin
        q_nxt     = q;
        carry_nxt = carry;
        case (mode)
            MODE_HOLD: begin
                q_nxt     = q;
                carry_nxt = carry;
            end
            MODE_LOAD: begin
                q_nxt     = data_in;
                carry_nxt = 1'b0;
            end
            MODE_SHL: begin
                q_nxt     = {q[WIDTH-2:0], ser_in};
                carry_nxt = q[WIDTH-1];
            end
            MODE_SHR: begin
                q_nxt     = {ser_in, q[WIDTH-1:1]};
                carry_nxt = q[0];
            end
            MODE_ROL: begin
                q_nxt     = {q[WIDTH-2:0], q[WIDTH-1]};
                carry_nxt = q[WIDTH-1];
            end
            MODE_ROR: begin
                q_nxt     = {q[0], q[WIDTH-1:1]};
                carry_nxt = q[0];
            end
            MODE_INC: begin
                q_nxt     = inc_s[WIDTH-1:0];
                carry_nxt = inc_s[WIDTH];
            end
            MODE_DEC: begin
                q_nxt     = dec_s[WIDTH-1:0];
                carry_nxt = dec_s[WIDTH];
            end
            default: begin
                q_nxt     = q;
                carry_nxt = carry;
            end
        endcase
    end

endmodule

// File: rtl/universal_register.sv
// Universal datapath register: load, shift, rotate, inc/dec with serial chaining
// and carry/zero status.
module universal_register
    import universal_register_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in,
    output logic [WIDTH-1:0] data_out,
    output logic             carry,
    output logic             ser_out,
    output logic             zero
);

    logic [WIDTH-1:0] q_nxt_s;
    logic             carry_nxt_s;

    universal_register_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .q         (data_out),
        .carry     (carry),
        .mode      (mode),
        .data_in   (data_in),
        .ser_in    (ser_in),
        .q_nxt     (q_nxt_s),
        .carry_nxt (carry_nxt_s)
    );

    // State register; reset takes priority over every mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= RESET_VALUE;
            carry    <= 1'b0;
        end else begin
            data_out <= q_nxt_s;
            carry    <= carry_nxt_s;
        end
    end

    // ser_out presents the bit that leaves on the next edge so stages can chain.
    always_comb begin
        ser_out = data_out[WIDTH-1];
        if (exits_lsb(mode)) begin
            ser_out = data_out[0];
        end else begin
            ser_out = data_out[WIDTH-1];
        end
    end

    assign zero = (data_out == {WIDTH{1'b0}});

endmodule

// File: tb/tb_universal_register.sv
// Self-checking bench: directed scenarios plus random stimulus against an arithmetic model.
module tb_universal_register;
    import universal_register_pkg::*;

    logic       clk;
    logic       rst;
    logic [2:0] mode;
    logic [7:0] data_in;
    logic       ser_in;
    logic [7:0] data_out;
    logic       carry;
    logic       ser_out;
    logic       zero;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state as plain integers
    int m_q = 0;
    int m_c = 0;
    bit m_valid = 1'b0;

    universal_register #(
        .WIDTH       (8),
        .RESET_VALUE (8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .data_in  (data_in),
        .ser_in   (ser_in),
        .data_out (data_out),
        .carry    (carry),
        .ser_out  (ser_out),
        .zero     (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit r, input logic [2:0] md, input int din, input int sin);
        int q;
        q = m_q;
        if (r) begin
            m_q = 0;
            m_c = 0;
            m_valid = 1'b1;
        end else begin
            case (md)
                MODE_HOLD: ;
                MODE_LOAD: begin m_q = din; m_c = 0; end
                MODE_SHL:  begin m_q = (q * 2 + sin) % 256; m_c = q / 128; end
                MODE_SHR:  begin m_q = q / 2 + sin * 128; m_c = q % 2; end
                MODE_ROL:  begin m_q = (q * 2) % 256 + q / 128; m_c = q / 128; end
                MODE_ROR:  begin m_q = q / 2 + (q % 2) * 128; m_c = q % 2; end
                MODE_INC:  begin m_q = (q + 1) % 256; m_c = (q == 255) ? 1 : 0; end
                MODE_DEC:  begin m_q = (q + 255) % 256; m_c = (q == 0) ? 1 : 0; end
                default: ;
            endcase
        end
    endtask

    // One clock: drive, check ser_out before the edge, then check state at negedge.
    task automatic step(input string tag, input bit r, input logic [2:0] md,
                        input logic [7:0] din, input bit sin);
        int exp_so;
        rst     = r;
        mode    = md;
        data_in = din;
        ser_in  = sin;
        #1;
        if (m_valid) begin
            exp_so = (md == MODE_SHR || md == MODE_ROR) ? (m_q % 2) : (m_q / 128);
            check({tag, "_ser_out"}, {31'd0, ser_out}, exp_so);
        end
        @(posedge clk);
        model_update(r, md, int'(din), int'(sin));
        @(negedge clk);
        check({tag, "_data"},  {24'd0, data_out}, m_q);
        check({tag, "_carry"}, {31'd0, carry}, m_c);
        check({tag, "_zero"},  {31'd0, zero}, (m_q == 0) ? 1 : 0);
    endtask

    task automatic expect_const(input string tag, input logic [7:0] q, input bit c);
        check({tag, "_kdata"},  {24'd0, data_out}, {24'd0, q});
        check({tag, "_kcarry"}, {31'd0, carry}, {31'd0, c});
    endtask

    initial begin
        rst = 1'b0; mode = MODE_HOLD; data_in = 8'h00; ser_in = 1'b0;

        // Reset dominates a concurrent LOAD
        step("t1", 1'b1, MODE_LOAD, 8'hFF, 1'b0);
        expect_const("t1", 8'h00, 1'b0);
        check("t1_kzero", {31'd0, zero}, 32'd1);

        step("t2a", 1'b0, MODE_LOAD, 8'h55, 1'b0);
        expect_const("t2a", 8'h55, 1'b0);
        step("t2b", 1'b0, MODE_SHL, 8'h00, 1'b1);
        expect_const("t2b", 8'hAB, 1'b0);
        check("t2b_kzero", {31'd0, zero}, 32'd0);

        step("t3a", 1'b0, MODE_LOAD, 8'h81, 1'b0);
        step("t3b", 1'b0, MODE_SHR, 8'h00, 1'b0);
        expect_const("t3b", 8'h40, 1'b1);
        step("t3c", 1'b0, MODE_ROR, 8'h00, 1'b0);
        expect_const("t3c", 8'h20, 1'b0);

        step("t4a", 1'b0, MODE_LOAD, 8'hFF, 1'b0);
        step("t4b", 1'b0, MODE_INC, 8'h00, 1'b0);
        expect_const("t4b", 8'h00, 1'b1);
        step("t4c", 1'b0, MODE_DEC, 8'h00, 1'b0);
        expect_const("t4c", 8'hFF, 1'b1);
        step("t4d", 1'b0, MODE_DEC, 8'h00, 1'b0);
        expect_const("t4d", 8'hFE, 1'b0);

        step("t5a", 1'b0, MODE_LOAD, 8'h01, 1'b0);
        for (int i = 0; i < 8; i++) step("t5rol", 1'b0, MODE_ROL, 8'h00, 1'b0);
        expect_const("t5rol", 8'h01, 1'b1);
        for (int i = 0; i < 3; i++) step("t5hold", 1'b0, MODE_HOLD, 8'hA5, 1'b1);
        expect_const("t5hold", 8'h01, 1'b1);

        step("t6a", 1'b0, MODE_LOAD, 8'h3C, 1'b0);
        step("t6b", 1'b0, MODE_SHL, 8'h00, 1'b0);
        expect_const("t6b", 8'h78, 1'b0);
        step("t6c", 1'b1, MODE_INC, 8'h00, 1'b0);
        expect_const("t6c", 8'h00, 1'b0);
        step("t6d", 1'b0, MODE_INC, 8'h00, 1'b0);
        expect_const("t6d", 8'h01, 1'b0);

        // Random traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            step("rnd", ($urandom_range(31) == 0), 3'($urandom_range(7)),
                 8'($urandom_range(255)), 1'($urandom_range(1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
